add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 The block SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port: req  input  3  per-requester add request, bit i = requester i.
REQ-005 The block SHALL have ports: a0/b0, a1/b1, a2/b2  input  WIDTH each  operands of requester 0/1/2.
REQ-006 The block SHALL have port: gnt  output  3  one-hot grant, combinational, bit i = requester i operands captured this cycle.
REQ-007 The block SHALL have port: res_valid  output  1  registered result present.
REQ-008 The block SHALL have port: res_ready  input  1  consumer accepts result this cycle.
REQ-009 The block SHALL have port: res_id  output  2  index of requester owning res_data.
REQ-010 The block SHALL have port: res_data  output  WIDTH  registered sum a+b, modulo 2^WIDTH.
REQ-011 The block SHALL have port: res_ovf  output  1  signed overflow flag of res_data.

Function
REQ-012 The block SHALL time-share one WIDTH-bit adder among three requesters; exactly one addition per grant.
REQ-013 FSM states SHALL be EMPTY (no result held) and FULL (result held, res_valid=1).
REQ-014 A grant SHALL be issuable when state is EMPTY, or FULL with res_ready=1 (pass-through); otherwise gnt=000.
REQ-015 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod 3, first asserted req wins.
REQ-016 On grant to i at edge N: res_data = ai+bi, res_id = i, res_valid = 1 from cycle N+1 (latency 1); last_granted <= i.
REQ-017 FULL with res_ready=1 and no req: next state EMPTY, res_valid=0.
REQ-018 FULL with res_ready=0: res_data, res_id, res_ovf, res_valid SHALL hold; gnt=000; pointer unchanged.
REQ-019 FULL with res_ready=1 and a req: result replaced next cycle, state stays FULL (full throughput, one result per cycle).
REQ-020 Requester i SHALL hold req/ai/bi until it sees gnt[i]=1; deasserting req before grant withdraws it without side effect.
REQ-021 Carry out of bit WIDTH-1 SHALL be discarded; no saturation.
REQ-022 gnt SHALL never have more than one bit set; gnt[i]=1 only when req[i]=1.
REQ-023 Single requester continuously asserting with res_ready=1 SHALL be granted every cycle.

Reset
REQ-024 With rst=1 at a rising edge: state EMPTY, res_valid=0, res_id=0, res_data=0, res_ovf=0, last_granted=2 (requester 0 has first priority).
REQ-025 While rst=1, gnt SHALL be 000; a result held at reset is discarded.
REQ-026 First grant after rst deasserts SHALL follow REQ-015 from last_granted=2.

Configuration
REQ-027 Macro ADD_ARB_OVF_EN SHALL select overflow detection.
REQ-028 Defined: res_ovf registered alongside res_data = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), held per REQ-018.
REQ-029 Undefined: res_ovf constant 0, no overflow logic synthesized; all other behaviour identical.

Verification
REQ-030 Reset then req=001, a0=5, b0=7, res_ready=1 -> gnt=001 same cycle; next cycle res_valid=1, res_id=0, res_data=12.
REQ-031 req=111 held, res_ready=1, 6 cycles -> gnt sequence 001,010,100,001,010,100; res_id follows one cycle later.
REQ-032 Result held, res_ready=0 for 3 cycles with req=010 -> gnt=000, res_data/res_id stable; res_ready=1 -> gnt=010 that cycle.
REQ-033 a1=0xFFFFFFFF, b1=1 -> res_data=0x00000000, res_ovf=0; a2=0x7FFFFFFF, b2=1 -> res_data=0x80000000, res_ovf=1 with ADD_ARB_OVF_EN, 0 without.
REQ-034 rst=1 asserted while FULL with res_ready=0 -> next cycle res_valid=0, res_data=0; after release req=110 -> gnt=010 first.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter time-sharing one WIDTH-bit adder among three requesters,
// with a one-entry result register. Define ADD_ARB_OVF_EN to enable the signed overflow flag.
module add_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b2,
  output logic [2:0]       gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_id,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               last_q, last_d;
  logic [1:0]               id_q, id_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic                     can_issue;
  logic [1:0]               sel;
  logic signed [WIDTH-1:0]  op_a, op_b, sum;

  // A new result may be written when the slot is empty or is being drained this cycle.
  assign can_issue = !rst && ((state_q == EMPTY) || res_ready);

  always_comb begin
    gnt = 3'b000;
    sel = 2'd0;
    // sel falls back to the lowest-priority requester, which is granted only if it asks.
    case (last_q)
      2'd0: begin
        if (req[1])      sel = 2'd1;
        else if (req[2]) sel = 2'd2;
        else             sel = 2'd0;
      end
      2'd1: begin
        if (req[2])      sel = 2'd2;
        else if (req[0]) sel = 2'd0;
        else             sel = 2'd1;
      end
      default: begin
        if (req[0])      sel = 2'd0;
        else if (req[1]) sel = 2'd1;
        else             sel = 2'd2;
      end
    endcase
    if (can_issue && req[sel]) gnt[sel] = 1'b1;
  end

  always_comb begin
    op_a = $signed(a2);
    op_b = $signed(b2);
    case (sel)
      2'd0: begin
        op_a = $signed(a0);
        op_b = $signed(b0);
      end
      2'd1: begin
        op_a = $signed(a1);
        op_b = $signed(b1);
      end
      default: ;
    endcase
    sum = op_a + op_b;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    data_d  = data_q;
    if (gnt != 3'b000) begin
      state_d = FULL;
      last_d  = sel;
      id_d    = sel;
      data_d  = sum;
    end else if ((state_q == FULL) && res_ready) begin
      state_d = EMPTY;
    end
  end

  // Result register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 2'd2;
      id_q    <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_id    = id_q;
  assign res_data  = data_q;

`ifdef ADD_ARB_OVF_EN
  function automatic logic ovf_f(input logic signed [WIDTH-1:0] a,
                                 input logic signed [WIDTH-1:0] b,
                                 input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (gnt != 3'b000) ovf_d = ovf_f(op_a, op_b, sum);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign res_ovf = ovf_q;
`else
  assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized and directed bench for add_arbiter against a transaction-level reference model.
module tb_add_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [W-1:0] a0, b0, a1, b1, a2, b2;
  logic [2:0]   gnt;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [W-1:0] res_data;
  logic         res_ovf;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one result slot plus the last-served requester.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  bit           m_ovf;
  int           m_last;

  add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner();
    if (rst) return -1;
    if (m_valid && !res_ready) return -1;
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (m_last + k) % 3;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] opa(input int i);
    return (i == 0) ? a0 : (i == 1) ? a1 : a2;
  endfunction

  function automatic logic [W-1:0] opb(input int i);
    return (i == 0) ? b0 : (i == 1) ? b1 : b2;
  endfunction

  // One clock: compare DUT with model mid-cycle, then advance the model at the edge.
  task automatic tick();
    int w;
    logic [2:0] eg;
    longint sa, sb, ss;
    #2;
    w  = exp_winner();
    eg = (w < 0) ? 3'b000 : 3'(1 << w);
    chk("gnt", 64'(gnt), 64'(eg));
    chk("res_valid", 64'(res_valid), 64'(m_valid));
    if (m_valid || rst) begin
      chk("res_id", 64'(res_id), 64'(m_id));
      chk("res_data", 64'(res_data), 64'(m_data));
      chk("res_ovf", 64'(res_ovf), 64'(m_ovf));
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_id = 0; m_ovf = 0; m_last = 2;
    end else if (w >= 0) begin
      m_valid = 1;
      m_id    = w;
      m_data  = opa(w) + opb(w);
      sa = longint'($signed(opa(w)));
      sb = longint'($signed(opb(w)));
      ss = sa + sb;
`ifdef ADD_ARB_OVF_EN
      m_ovf = (ss > (64'sd1 <<< (W-1)) - 1) || (ss < -(64'sd1 <<< (W-1)));
`else
      m_ovf = 0;
`endif
      m_last = w;
    end else if (m_valid && res_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] rr_seq [6];
    logic [W-1:0] held_data;
    logic [1:0]   held_id;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;

    rst = 1'b1; req = 3'b000; res_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    m_valid = 0; m_data = '0; m_id = 0; m_ovf = 0; m_last = 2;
    @(posedge clk); #1;

    // Reset holds gnt low even with all requests asserted.
    req = 3'b111; res_ready = 1'b1;
    #1 chk("gnt_in_reset", 64'(gnt), 64'(3'b000));
    tick();
    rst = 1'b0; req = 3'b000;
    #1 chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    tick();

    // Single add, latency one.
    req = 3'b001; a0 = 32'd5; b0 = 32'd7;
    #1 chk("single_gnt", 64'(gnt), 64'(3'b001));
    tick();
    req = 3'b000;
    #1 chk("single_data", 64'(res_data), 64'd12);
    chk("single_id", 64'(res_id), 64'd0);
    chk("single_valid", 64'(res_valid), 64'd1);
    tick();

    // Round robin with all three requesting, from reset.
    do_reset();
    req = 3'b111; res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_gnt", 64'(gnt), 64'(rr_seq[i]));
      tick();
    end

    // Backpressure: result must hold and no grant issued.
    req = 3'b010; res_ready = 1'b0;
    #1 held_data = res_data; held_id = res_id;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", 64'(res_data), 64'(held_data));
      chk("bp_id", 64'(res_id), 64'(held_id));
      chk("bp_gnt", 64'(gnt), 64'(3'b000));
    end
    res_ready = 1'b1;
    #1 chk("bp_release_gnt", 64'(gnt), 64'(3'b010));
    tick();

    // Carry discard and signed overflow.
    req = 3'b010; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
    tick();
    req = 3'b000;
    #1 chk("wrap_data", 64'(res_data), 64'd0);
    chk("wrap_ovf", 64'(res_ovf), 64'd0);
    req = 3'b100; a2 = 32'h7FFF_FFFF; b2 = 32'd1;
    tick();
    req = 3'b000;
    #1 chk("ovf_data", 64'(res_data), 64'h8000_0000);
`ifdef ADD_ARB_OVF_EN
    chk("ovf_flag", 64'(res_ovf), 64'd1);
`else
    chk("ovf_flag", 64'(res_ovf), 64'd0);
`endif
    tick();

    // Reset while FULL under backpressure discards the result.
    req = 3'b001; a0 = 32'd9; b0 = 32'd9;
    tick();
    res_ready = 1'b0; req = 3'b000;
    tick();
    do_reset();
    #1 chk("rst_full_valid", 64'(res_valid), 64'd0);
    chk("rst_full_data", 64'(res_data), 64'd0);
    req = 3'b110; res_ready = 1'b1;
    #1 chk("post_rst_gnt", 64'(gnt), 64'(3'b010));
    tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req       = 3'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      a0 = $urandom; b0 = $urandom;
      a1 = $urandom; b1 = $urandom;
      a2 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 : $urandom;
      b2 = $urandom;
      tick();
    end

    // Single requester with ready held is granted every cycle.
    rst = 1'b0; res_ready = 1'b1; req = 3'b100;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 chk("stream_gnt", 64'(gnt), 64'(3'b100));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
